result_bus_arbiter: RTL and testbench
=====================================

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of result producers (e.g. ALU, FPU, branch, memory); legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  pipeline flush; drops held result.
REQ-005 req_en  input  N_REQ  per-producer valid, Message sender side.
REQ-006 req_msg  input  N_REQ x Result  per-producer packed Result (commit_id, kind, content).
REQ-007 req_reject  output  N_REQ  per-producer reject; a transfer occurs when req_en[i] & !req_reject[i].
REQ-008 out_en  output  1  held Result valid toward commit buffer.
REQ-009 out_msg  output  Result  held Result.
REQ-010 out_reject  input  1  commit buffer cannot accept this cycle.

Function
REQ-011 Handshake: a sender SHALL hold req_en and req_msg stable while rejected; the block relies on this and SHALL NOT latch unaccepted messages.
REQ-012 One-entry output register (valid bit + Result); out_en SHALL equal the valid bit, out_msg the stored Result.
REQ-013 Drain: when out_en & !out_reject the entry SHALL be considered consumed at that edge.
REQ-014 Slot free this cycle = !valid | (valid & !out_reject); grant SHALL be issued only when the slot is free and flush=0.
REQ-015 Grant: among requesters with req_en=1, select the first at or after rr_ptr (modulo N_REQ); at most one grant per cycle.
REQ-016 req_reject[i] SHALL be 0 only for the granted index; all others, and all when no grant, SHALL be 1 (combinational from req_en, out_reject, flush, state).
REQ-017 On grant of index g: output register SHALL load req_msg[g] with valid=1 at the next edge; latency input-accept to out_en = 1 cycle.
REQ-018 On grant of g: rr_ptr SHALL become (g+1) mod N_REQ; with no grant rr_ptr SHALL hold.
REQ-019 Drain without grant: valid SHALL clear at the edge; drain with grant: register SHALL be overwritten (back-to-back, 1 result/cycle sustained).
REQ-020 Held and rejected (valid & out_reject): register and rr_ptr SHALL hold; all req_reject=1.
REQ-021 flush=1: valid SHALL clear at the edge regardless of out_reject, no grant that cycle, rr_ptr holds; out_en may be 1 in the flush cycle but the consumer ignores it.
REQ-022 No starvation: any requester holding req_en SHALL be granted within N_REQ free slots (without REQ-026 enabled).

Reset
REQ-023 While rstn=0 at an edge: valid=0, out_msg=0, rr_ptr=0.
REQ-024 During the reset cycle req_reject SHALL be all 1 and out_en 0 the following cycle; reset mid-transfer discards the held entry.

Configuration
REQ-025 Macro RESULT_ARB_BRANCH_PRIO_EN.
REQ-026 Defined: requesters whose req_msg.kind=1 (branch) SHALL win over kind=0 ones; round-robin order applies within each class; rr_ptr updates per REQ-018; starvation bound of REQ-022 applies only to branch results.
REQ-027 Undefined: pure round-robin per REQ-015, kind ignored.

Verification
REQ-028 Reset, then req_en=0001, msg.commit_id=5, out_reject=0 -> req_reject=1110, next cycle out_en=1, commit_id=5, rr_ptr=1.
REQ-029 req_en=1111 held 4 cycles, out_reject=0, rr_ptr=0 -> grants 0,1,2,3 in order; out_en=1 for 4 consecutive cycles.
REQ-030 Entry held, out_reject=1 for 3 cycles, req_en=0010 -> req_reject=1111 throughout; out_msg stable; on out_reject=0 same cycle grant 1 and out_msg updates next cycle.
REQ-031 Entry held, flush=1 with req_en=0100 -> req_reject=1111, out_en=0 next cycle, rr_ptr unchanged.
REQ-032 With RESULT_ARB_BRANCH_PRIO_EN, rr_ptr=0, req_en=0011, req1.kind=1, req0.kind=0 -> grant 1 first, grant 0 next cycle; without macro -> grant 0 first.
REQ-033 Drive rstn=0 while out_en=1 and out_reject=1 -> out_en=0 after the edge, rr_ptr=0, no stale entry after rstn=1.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that funnels N_REQ result producers into one held output slot.
// Define RESULT_ARB_BRANCH_PRIO_EN to let branch results (kind=1) win over all others.
module result_bus_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 6,
  parameter int DATA_W = 16,
  localparam int MSG_W = ID_W + 1 + DATA_W,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_en,
  input  logic [N_REQ*MSG_W-1:0] req_msg,
  output logic [N_REQ-1:0]       req_reject,
  output logic                   out_en,
  output logic [MSG_W-1:0]       out_msg,
  input  logic                   out_reject
);

  // Message layout per producer: {commit_id, kind, content}; kind sits right above content.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] idx_b;
    int               idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % N_REQ;
      idx_b = idx[PTR_W-1:0];
      if (cand[idx_b]) res = {1'b1, idx_b};
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    int nxt;
    nxt = (int'(g) + 1) % N_REQ;
    return nxt[PTR_W-1:0];
  endfunction

  logic                   vld_p0;
  logic [MSG_W-1:0]       msg_p0;
  logic [PTR_W-1:0]       rr_ptr;
  logic [N_REQ-1:0]       kind_vec;
  logic [N_REQ-1:0]       cand;
  logic [PTR_W:0]         pick;
  logic                   slot_free;
  logic                   grant;
  logic [PTR_W-1:0]       gidx;
  logic [MSG_W-1:0]       gmsg;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) kind_vec[i] = req_msg[i*MSG_W + DATA_W];
  end

  always_comb begin
    cand = req_en;
`ifdef RESULT_ARB_BRANCH_PRIO_EN
    if (|(req_en & kind_vec)) cand = req_en & kind_vec;
`endif
    pick       = rr_pick(cand, rr_ptr);
    slot_free  = !vld_p0 || !out_reject;
    // Reset is folded in so nothing is ever accepted during the reset cycle.
    grant      = pick[PTR_W] && slot_free && !flush && rstn;
    gidx       = pick[PTR_W-1:0];
    gmsg       = req_msg[int'(gidx)*MSG_W +: MSG_W];
    req_reject = grant ? ~({{(N_REQ-1){1'b0}}, 1'b1} << gidx) : '1;
  end

  // Output slot stage: overwrite on grant, clear on drain or flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
      msg_p0 <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (grant) begin
      vld_p0 <= 1'b1;
      msg_p0 <= gmsg;
      rr_ptr <= next_ptr(gidx);
    end else if (vld_p0 && !out_reject) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_en  = vld_p0;
  assign out_msg = msg_p0;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Randomized scoreboard bench for result_bus_arbiter with a queue-based reference model.
module tb_result_bus_arbiter;
  localparam int N      = 4;
  localparam int ID_W   = 6;
  localparam int DATA_W = 16;
  localparam int MSG_W  = ID_W + 1 + DATA_W;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               flush = 1'b0;
  logic [N-1:0]       req_en = '0;
  logic [N*MSG_W-1:0] req_msg = '0;
  logic [N-1:0]       req_reject;
  logic               out_en;
  logic [MSG_W-1:0]   out_msg;
  logic               out_reject = 1'b0;

  result_bus_arbiter #(.N_REQ(N), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .req_en(req_en), .req_msg(req_msg),
    .req_reject(req_reject), .out_en(out_en), .out_msg(out_msg), .out_reject(out_reject)
  );

  always #5 clk = ~clk;

  logic [MSG_W-1:0] exp_q[$];
  logic [MSG_W-1:0] msg_a[N];
  logic [N-1:0]     en_a;
  int               rr_m;
  int               checks = 0;
  int               errors = 0;
  bit               mon_on = 1'b0;

  // Reference: branch class (if enabled) beats the rest, then first requester from rr_m upward.
  function automatic int model_grant(input logic [N-1:0] en);
    logic [N-1:0] c;
    logic [N-1:0] br;
    c = en;
    for (int i = 0; i < N; i++) br[i] = msg_a[i][DATA_W];
`ifdef RESULT_ARB_BRANCH_PRIO_EN
    if ((en & br) != '0) c = en & br;
`endif
    for (int k = 0; k < N; k++)
      if (c[(rr_m + k) % N]) return (rr_m + k) % N;
    return -1;
  endfunction

  task automatic step(input logic rn, input logic fl, input logic orej, output int g);
    logic [N-1:0] exp_rej;
    for (int i = 0; i < N; i++) req_msg[i*MSG_W +: MSG_W] = msg_a[i];
    req_en = en_a; rstn = rn; flush = fl; out_reject = orej;
    g = -1;
    if (rn && !fl && (exp_q.size() == 0 || !orej)) g = model_grant(en_a);
    exp_rej = '1;
    if (g >= 0) exp_rej[g] = 1'b0;
    #1;
    checks++;
    if (req_reject !== exp_rej) begin
      errors++;
      $display("FAIL req_reject: got %b expected %b (en=%b rr=%0d)", req_reject, exp_rej, en_a, rr_m);
    end
    @(posedge clk); #1;
    if (!rn) begin
      exp_q.delete(); rr_m = 0;
    end else if (fl) begin
      exp_q.delete();
    end else if (g >= 0) begin
      exp_q.delete(); exp_q.push_back(msg_a[g]); rr_m = (g + 1) % N;
    end
  endtask

  // Monitor: checks the slot's valid and pops on every consumed result.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (out_en !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_en: got %b expected %b", out_en, exp_q.size() != 0);
      end else if (out_en && rstn && !flush && !out_reject && exp_q.size() > 0) begin
        checks++;
        if (out_msg !== exp_q[0]) begin
          errors++;
          $display("FAIL out_msg: got %h expected %h", out_msg, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int g;
    int last_g;
    int exp_first;
    logic [31:0] r;
    en_a = '0;
    for (int i = 0; i < N; i++) msg_a[i] = '0;
    rr_m = 0;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b0, g);
    mon_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, g);
    checks++;
    if (out_msg !== '0) begin
      errors++;
      $display("FAIL reset_out_msg: got %h expected 0", out_msg);
    end

    // Single requester 0 with commit_id 5, then idle so the monitor drains it.
    en_a = 4'b0001;
    msg_a[0] = {6'd5, 1'b0, 16'h1234};
    step(1'b1, 1'b0, 1'b0, g);
    en_a = '0;
    step(1'b1, 1'b0, 1'b0, g);
    checks++;
    if (g != -1) begin
      errors++;
      $display("FAIL idle_grant: got %0d expected -1", g);
    end

    // Two requesters, only producer 1 is a branch, pointer back at 0.
    step(1'b0, 1'b0, 1'b0, g);
    en_a = 4'b0011;
    msg_a[0] = {6'd10, 1'b0, 16'h00aa};
    msg_a[1] = {6'd11, 1'b1, 16'h00bb};
`ifdef RESULT_ARB_BRANCH_PRIO_EN
    exp_first = 1;
`else
    exp_first = 0;
`endif
    step(1'b1, 1'b0, 1'b0, g);
    checks++;
    if (g != exp_first) begin
      errors++;
      $display("FAIL prio_first: got %0d expected %0d", g, exp_first);
    end
    en_a[g] = 1'b0;
    step(1'b1, 1'b0, 1'b0, g);
    checks++;
    if (g != 1 - exp_first) begin
      errors++;
      $display("FAIL prio_second: got %0d expected %0d", g, 1 - exp_first);
    end
    en_a = '0;
    step(1'b1, 1'b0, 1'b0, g);

    // Random traffic; senders hold en/msg stable while rejected.
    last_g = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(en_a[i] && last_g != i)) begin
          en_a[i] = ($urandom_range(0, 9) < 6);
          r = $urandom;
          msg_a[i] = r[MSG_W-1:0];
        end
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) == 0), g);
      last_g = g;
    end

    en_a = '0;
    step(1'b1, 1'b0, 1'b0, g);
    step(1'b1, 1'b0, 1'b0, g);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
